trace_fifo: RTL and testbench
=============================

TRACE_FIFO -- requirements
Module: trace_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of trace entries; power of two, 4 to 64.
REQ-002 Parameter STOP_ON_FULL, default 1; 1 = freeze capture on first drop, 0 = keep capturing and dropping.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  capture enable; high = record pc_in/instr_in this cycle.
REQ-006 clear  input  1  synchronous flush of entries, flags and counters.
REQ-007 pc_in  input  32  PC of the instruction retiring this cycle, taken from the core PC output.
REQ-008 instr_in  input  32  instruction word retiring this cycle, taken from the core instruction output.
REQ-009 out_ready  input  1  consumer accepts the head entry this cycle.
REQ-010 out_valid  output  1  head entry present.
REQ-011 out_pc  output  32  PC of head entry.
REQ-012 out_instr  output  32  instruction of head entry.
REQ-013 count  output  $clog2(DEPTH)+1  entries stored.
REQ-014 overflow  output  1  sticky; set on any dropped capture.
REQ-015 dropped_cnt  output  16  dropped captures, saturating at 16'hFFFF.
REQ-016 state  output  2  00 IDLE, 01 RUN, 10 FROZEN.

Function
REQ-017 The FIFO SHALL store {pc_in, instr_in} pairs in a circular buffer with read/write pointers wrapping from DEPTH-1 to 0.
REQ-018 Capture attempt SHALL be defined as en=1, clear=0 and state!=FROZEN; a pop SHALL be defined as out_valid=1, out_ready=1 and clear=0.
REQ-019 A capture attempt with count<DEPTH SHALL write the entry; count SHALL increase by 1 unless a pop occurs in the same cycle.
REQ-020 A capture attempt with count=DEPTH and no pop SHALL be dropped: overflow set, dropped_cnt incremented (saturating), no entry overwritten.
REQ-021 A capture attempt with count=DEPTH and a simultaneous pop SHALL succeed; count stays DEPTH; no drop.
REQ-022 No fall-through: an entry written in cycle N SHALL first be visible on out_valid/out_pc/out_instr in cycle N+1; when empty, a push and out_ready in the same cycle SHALL produce no pop.
REQ-023 out_pc/out_instr SHALL hold the head entry stable while out_valid=1 and out_ready=0; SHALL be 0 when out_valid=0.
REQ-024 out_valid SHALL equal (count!=0).
REQ-025 State transitions: IDLE->RUN when en=1; RUN->IDLE when en=0; RUN->FROZEN on a drop when STOP_ON_FULL=1; FROZEN->IDLE only on clear=1.
REQ-026 With STOP_ON_FULL=0, FROZEN SHALL be unreachable.
REQ-027 In FROZEN, pops SHALL continue normally; no captures occur and dropped_cnt does not change.
REQ-028 clear=1 SHALL take priority over capture and pop: next cycle count=0, pointers=0, overflow=0, dropped_cnt=0, state=IDLE.
REQ-029 Stored entries SHALL be returned in capture order with no duplication or reordering across pointer wrap.

Reset
REQ-030 rst_n=0 at a rising edge SHALL set count=0, pointers=0, out_valid=0, out_pc=0, out_instr=0, overflow=0, dropped_cnt=0, state=IDLE, with priority over clear, en and out_ready.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries; the first capture after rst_n returns high SHALL appear at the head.
REQ-032 Storage array contents need not be reset; only pointers and flags are reset.

Verification
REQ-033 Basic: reset, en=1 for 3 cycles with pc_in 0,4,8, out_ready=0 -> count=3, out_pc=0; then out_ready=1 -> out_pc 0,4,8 on consecutive cycles, then out_valid=0.
REQ-034 Overflow freeze (DEPTH=16, STOP_ON_FULL=1): 17 captures, out_ready=0 -> count=16, overflow=1, dropped_cnt=1, state=FROZEN; further en gives dropped_cnt=1 unchanged.
REQ-035 Full with pop: fill to 16, then capture and pop together for 20 cycles -> count stays 16, overflow=0, output order matches input order across wrap.
REQ-036 Clear from FROZEN: clear=1 one cycle -> count=0, overflow=0, dropped_cnt=0, state=IDLE; next en=1 captures normally.
REQ-037 STOP_ON_FULL=0: 20 captures with out_ready=0 -> count=16, dropped_cnt=4, state=RUN, head is the first captured entry.
REQ-038 Reset mid-run: 5 entries stored, rst_n=0 one cycle -> all outputs 0, state=IDLE; next capture pc_in=32'h40 appears as out_pc=32'h40.

Source files
------------

// File: rtl/trace_fifo_if.sv
// trace_fifo_if: capture, consumer and status signals of the trace FIFO.
//   master drives en/clear/pc_in/instr_in/out_ready; slave (the FIFO) drives
//   out_valid/out_pc/out_instr/count/overflow/dropped_cnt/state.
interface trace_fifo_if #(parameter int DEPTH = 16) ();
  localparam int CW = $clog2(DEPTH) + 1;
  logic en, clear, out_ready, out_valid, overflow;
  logic [31:0] pc_in, instr_in, out_pc, out_instr;
  logic [CW-1:0] count;
  logic [15:0] dropped_cnt;
  logic [1:0] state;
  modport master (
    output en, clear, pc_in, instr_in, out_ready,
    input out_valid, out_pc, out_instr, count, overflow, dropped_cnt, state
  );
  modport slave (
    input en, clear, pc_in, instr_in, out_ready,
    output out_valid, out_pc, out_instr, count, overflow, dropped_cnt, state
  );
endinterface

// File: rtl/trace_fifo.sv
// trace_fifo: circular buffer of retired {pc, instr} pairs with drop accounting.
//   clk, rst_n (sync, active-low) plain ports; bus carries capture inputs,
//   head entry with valid/ready, count, sticky overflow, dropped_cnt, state.
module trace_fifo #(
  parameter int DEPTH        = 16,
  parameter bit STOP_ON_FULL = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  trace_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, FROZEN = 2'b10} state_e;
  state_e state_q, state_d;
  logic [63:0] mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  logic [15:0] dropped_q, dropped_d;
  logic overflow_q, overflow_d, cap, pop, push, drop;
  assign cap  = bus.en & ~bus.clear & (state_q != FROZEN);
  assign pop  = (count_q != '0) & bus.out_ready & ~bus.clear;
  // a full buffer still accepts a capture when the head leaves in the same cycle
  assign push = cap & ((count_q != FULL) | pop);
  assign drop = cap & (count_q == FULL) & ~pop;
  always_comb begin
    wptr_d     = bus.clear ? '0 : wptr_q + AW'(push);
    rptr_d     = bus.clear ? '0 : rptr_q + AW'(pop);
    count_d    = bus.clear ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    overflow_d = ~bus.clear & (overflow_q | drop);
    dropped_d  = bus.clear ? '0 : dropped_q + 16'(drop & ~&dropped_q);
    state_d    = bus.clear ? IDLE :
                 state_q == IDLE ? (bus.en ? RUN : IDLE) :
                 state_q == RUN ? (!bus.en ? IDLE : (drop && STOP_ON_FULL) ? FROZEN : RUN) :
                 state_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      dropped_q  <= '0;
      state_q    <= IDLE;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
      state_q    <= state_d;
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wptr_q] <= {bus.pc_in, bus.instr_in};
  assign bus.out_valid   = count_q != '0;
  assign bus.out_pc      = bus.out_valid ? mem[rptr_q][63:32] : '0;
  assign bus.out_instr   = bus.out_valid ? mem[rptr_q][31:0] : '0;
  assign bus.count       = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.dropped_cnt = dropped_q;
  assign bus.state       = state_q;
endmodule

// File: tb/tb_trace_fifo.sv
// tb_trace_fifo: drives a freezing and a non-freezing FIFO with the same stimulus against a queue model.
module tb_trace_fifo;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, clear = 1'b0, rdy = 1'b0;
  logic [31:0] pc = '0, ins = '0;
  always #5 clk = ~clk;
  trace_fifo_if #(.DEPTH(16)) b0 ();
  trace_fifo_if #(.DEPTH(16)) b1 ();
  assign b0.en = en;
  assign b0.clear = clear;
  assign b0.pc_in = pc;
  assign b0.instr_in = ins;
  assign b0.out_ready = rdy;
  assign b1.en = en;
  assign b1.clear = clear;
  assign b1.pc_in = pc;
  assign b1.instr_in = ins;
  assign b1.out_ready = rdy;
  trace_fifo #(.DEPTH(16), .STOP_ON_FULL(1'b1)) d0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  trace_fifo #(.DEPTH(16), .STOP_ON_FULL(1'b0)) d1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  int n_chk = 0, n_fail = 0;
  logic [63:0] q0[$], q1[$];
  bit ov[2];
  int dc[2], st[2];
  function automatic int qsize(int k);
    return k == 0 ? q0.size() : q1.size();
  endfunction
  function automatic logic [63:0] qhead(int k);
    if (qsize(k) == 0) return '0;
    return k == 0 ? q0[0] : q1[0];
  endfunction
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model(int k);
    int sz = qsize(k);
    bit cap, pop, drop;
    if (!rst_n || clear) begin
      if (k == 0) q0.delete(); else q1.delete();
      ov[k] = 0;
      dc[k] = 0;
      st[k] = 0;
      return;
    end
    cap  = en && st[k] != 2;
    pop  = sz != 0 && rdy;
    drop = cap && sz == 16 && !pop;
    if (pop) begin
      if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
    if (cap && !drop) begin
      if (k == 0) q0.push_back({pc, ins}); else q1.push_back({pc, ins});
    end
    if (drop) begin
      ov[k] = 1;
      if (dc[k] < 65535) dc[k]++;
    end
    if (st[k] == 0) st[k] = en ? 1 : 0;
    else if (st[k] == 1) st[k] = !en ? 0 : (drop && k == 0) ? 2 : 1;
  endtask
  task automatic chk_dut(int k, logic v, logic [31:0] p, logic [31:0] i, logic [4:0] c,
                         logic o, logic [15:0] d, logic [1:0] s);
    string t = k == 0 ? "stop" : "nostop";
    logic [63:0] h = qhead(k);
    chk({t, ".valid"}, 64'(v), 64'(qsize(k) != 0));
    chk({t, ".pc"}, 64'(p), 64'(h[63:32]));
    chk({t, ".instr"}, 64'(i), 64'(h[31:0]));
    chk({t, ".count"}, 64'(c), 64'(qsize(k)));
    chk({t, ".overflow"}, 64'(o), 64'(ov[k]));
    chk({t, ".dropped"}, 64'(d), 64'(dc[k]));
    chk({t, ".state"}, 64'(s), 64'(st[k]));
  endtask
  task automatic tick(bit r, bit e, bit c, bit rd, logic [31:0] p, logic [31:0] i);
    rst_n = r; en = e; clear = c; rdy = rd; pc = p; ins = i;
    model(0);
    model(1);
    @(posedge clk);
    #1;
    chk_dut(0, b0.out_valid, b0.out_pc, b0.out_instr, b0.count, b0.overflow, b0.dropped_cnt, b0.state);
    chk_dut(1, b1.out_valid, b1.out_pc, b1.out_instr, b1.count, b1.overflow, b1.dropped_cnt, b1.state);
  endtask
  initial begin
    tick(0, 1, 1, 1, 32'h1234, 32'h5678);
    chk("reset.count", 64'(b0.count), 64'd0);
    chk("reset.pc", 64'(b0.out_pc), 64'd0);
    for (int i = 0; i < 3; i++) tick(1, 1, 0, 0, 32'(i * 4), $urandom);
    chk("basic.count", 64'(b0.count), 64'd3);
    chk("basic.head", 64'(b0.out_pc), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("basic.order", 64'(b0.out_pc), 64'(i * 4));
      tick(1, 0, 0, 1, $urandom, $urandom);
    end
    chk("basic.empty", 64'(b0.out_valid), 64'd0);
    for (int i = 0; i < 17; i++) tick(1, 1, 0, 0, 32'h100 + 32'(i * 4), $urandom);
    chk("freeze.count", 64'(b0.count), 64'd16);
    chk("freeze.overflow", 64'(b0.overflow), 64'd1);
    chk("freeze.dropped", 64'(b0.dropped_cnt), 64'd1);
    chk("freeze.state", 64'(b0.state), 64'd2);
    for (int i = 0; i < 3; i++) tick(1, 1, 0, 0, $urandom, $urandom);
    chk("freeze.dropped_hold", 64'(b0.dropped_cnt), 64'd1);
    chk("nostop.count", 64'(b1.count), 64'd16);
    chk("nostop.dropped", 64'(b1.dropped_cnt), 64'd4);
    chk("nostop.state", 64'(b1.state), 64'd1);
    chk("nostop.head", 64'(b1.out_pc), 64'h100);
    tick(1, 1, 1, 1, $urandom, $urandom);
    chk("clear.count", 64'(b0.count), 64'd0);
    chk("clear.overflow", 64'(b0.overflow), 64'd0);
    chk("clear.dropped", 64'(b0.dropped_cnt), 64'd0);
    chk("clear.state", 64'(b0.state), 64'd0);
    tick(1, 1, 0, 1, 32'h200, $urandom);
    chk("clear.recapture", 64'(b0.out_pc), 64'h200);
    for (int i = 0; i < 15; i++) tick(1, 1, 0, 0, 32'h300 + 32'(i), $urandom);
    chk("fullpop.fill", 64'(b0.count), 64'd16);
    for (int i = 0; i < 20; i++) tick(1, 1, 0, 1, 32'h400 + 32'(i), $urandom);
    chk("fullpop.count", 64'(b0.count), 64'd16);
    chk("fullpop.overflow", 64'(b0.overflow), 64'd0);
    chk("fullpop.head", 64'(b0.out_pc), 64'h404);
    tick(1, 0, 1, 0, $urandom, $urandom);
    for (int i = 0; i < 5; i++) tick(1, 1, 0, 0, $urandom, $urandom);
    tick(0, 1, 0, 1, $urandom, $urandom);
    chk("rstmid.valid", 64'(b0.out_valid), 64'd0);
    chk("rstmid.count", 64'(b0.count), 64'd0);
    chk("rstmid.pc", 64'(b0.out_pc), 64'd0);
    tick(1, 1, 0, 0, 32'h40, $urandom);
    chk("rstmid.head", 64'(b0.out_pc), 64'h40);
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0,
           $urandom_range(0, 9) < (i < 200 ? 3 : 8), $urandom, $urandom);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
